vram_arbiter: RTL and testbench

Single-port video-RAM arbiter for the invaders frame buffer. It shares one synchronous-read byte RAM between two requesters: the VGA fetcher (strobe-based reads) and the CPU bus (request/acknowledge reads and writes). The VGA fetcher has absolute priority and a bounded read latency. The block sits between the vga block's `o_addr`/`o_read`/`i_ready`/`i_data` port pair and the RAM macro.

---
 rtl/vram_arbiter.sv | 151 +++++++++++++++
 tb/tb_vram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer RAM arbiter: strobe-based video reads take priority over
// request/ack CPU reads and writes. Define VRAM_ARB_STATS_EN to add the o_stall_cnt counter.
module vram_arbiter #(
  parameter int VRAM_BYTES = 7168
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [12:0] i_vid_addr,
  input  logic        i_vid_read,
  output logic [7:0]  o_vid_data,
  output logic        o_vid_ready,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [12:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_ack,
  output logic [12:0] o_mem_addr,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0] o_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    VRD,
    VDAT,
    CRD,
    CDAT,
    CWR,
    CNUL
  } state_t;

  localparam logic [12:0] ADDR_LIMIT = 13'(VRAM_BYTES);

  state_t      state;
  logic        vid_pend;
  logic [12:0] vid_addr_q;

  logic        vid_want;
  logic [12:0] vid_addr_sel;
  logic        vid_grant;
  logic        cpu_take;
  logic        cpu_oob;

  // A strobe arriving in the grant cycle itself is newer than anything pending.
  assign vid_want     = vid_pend | i_vid_read;
  assign vid_addr_sel = i_vid_read ? i_vid_addr : vid_addr_q;
  assign vid_grant    = vid_want && (state == IDLE || state == CDAT ||
                                     state == CWR  || state == CNUL);
  assign cpu_take     = (state == IDLE) && !vid_want && i_cpu_req && !o_cpu_ack;
  assign cpu_oob      = (i_cpu_addr >= ADDR_LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      vid_pend    <= 1'b0;
      vid_addr_q  <= '0;
      o_vid_data  <= '0;
      o_vid_ready <= 1'b0;
      o_cpu_rdata <= '0;
      o_cpu_ack   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_wdata <= '0;
    end else begin
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_vid_ready <= 1'b0;
      o_cpu_ack   <= 1'b0;

      if (i_vid_read) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= i_vid_addr;
      end

      case (state)
        IDLE: begin
          if (cpu_take) begin
            o_mem_addr <= i_cpu_addr;
            if (cpu_oob) begin
              state <= CNUL;
            end else if (i_cpu_we) begin
              state       <= CWR;
              o_mem_en    <= 1'b1;
              o_mem_we    <= 1'b1;
              o_mem_wdata <= i_cpu_wdata;
            end else begin
              state    <= CRD;
              o_mem_en <= 1'b1;
            end
          end
        end
        VRD:  state <= VDAT;
        VDAT: begin
          o_vid_data  <= i_mem_rdata;
          o_vid_ready <= 1'b1;
          state       <= IDLE;
        end
        CRD:  state <= CDAT;
        CDAT: begin
          o_cpu_rdata <= i_mem_rdata;
          o_cpu_ack   <= 1'b1;
          state       <= IDLE;
        end
        CWR: begin
          o_cpu_ack <= 1'b1;
          state     <= IDLE;
        end
        CNUL: begin
          if (!i_cpu_we) o_cpu_rdata <= 8'h00;
          o_cpu_ack <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // NOTE: later non-blocking assignments to the same variable win, so the video grant
      // below overrides the IDLE/completion next-state and the pending-flag set above.
      if (vid_grant) begin
        state      <= VRD;
        o_mem_en   <= 1'b1;
        o_mem_we   <= 1'b0;
        o_mem_addr <= vid_addr_sel;
        vid_pend   <= 1'b0;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic stall_evt;

  assign stall_evt = i_cpu_req && !o_cpu_ack &&
                     (state == VRD || state == VDAT || (state == IDLE && vid_want));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
    end else if (stall_evt && o_stall_cnt != 16'hFFFF) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: drivers push expected completions, a negedge monitor
// pops and compares them against o_vid_ready / o_cpu_ack. Backing RAM is modelled here.
module tb_vram_arbiter;

  localparam int VRAM_BYTES = 7168;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [12:0] i_vid_addr;
  logic        i_vid_read;
  logic [7:0]  o_vid_data;
  logic        o_vid_ready;
  logic        i_cpu_req;
  logic        i_cpu_we;
  logic [12:0] i_cpu_addr;
  logic [7:0]  i_cpu_wdata;
  logic [7:0]  o_cpu_rdata;
  logic        o_cpu_ack;
  logic [12:0] o_mem_addr;
  logic        o_mem_en;
  logic        o_mem_we;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  i_mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] o_stall_cnt;
`endif

  vram_arbiter #(.VRAM_BYTES(VRAM_BYTES)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_vid_addr  (i_vid_addr),
    .i_vid_read  (i_vid_read),
    .o_vid_data  (o_vid_data),
    .o_vid_ready (o_vid_ready),
    .i_cpu_req   (i_cpu_req),
    .i_cpu_we    (i_cpu_we),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_wdata (i_cpu_wdata),
    .o_cpu_rdata (o_cpu_rdata),
    .o_cpu_ack   (o_cpu_ack),
    .o_mem_addr  (o_mem_addr),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    ,
    .o_stall_cnt (o_stall_cnt)
`endif
  );

  always #20 i_clk = ~i_clk;

  typedef struct {
    int         lo;
    int         hi;
    logic [7:0] data;
    bit         chk_data;
  } exp_t;

  exp_t vid_q[$];
  exp_t cpu_q[$];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  en_cnt = 0;
  bit  vid_done;

  logic [7:0] ram [0:VRAM_BYTES-1];

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 3);
  endfunction

  // Synchronous-read RAM: data valid the cycle after the edge that saw o_mem_en.
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_mem_en) begin
      if (o_mem_we) begin
        if (int'(o_mem_addr) < VRAM_BYTES) ram[o_mem_addr] <= o_mem_wdata;
      end else begin
        i_mem_rdata <= (int'(o_mem_addr) < VRAM_BYTES) ? ram[o_mem_addr] : 8'h00;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_win(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got cycle %0d expected [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  // Monitor: every completion must match the oldest expectation of its requester.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_mem_en === 1'b1) en_cnt++;
    if (o_vid_ready === 1'b1) begin
      if (vid_q.size() == 0) begin
        check("vid_ready_expected", vid_q.size(), 1);
      end else begin
        e = vid_q.pop_front();
        check_win("vid_ready_cycle", cyc, e.lo, e.hi);
        check("vid_data", o_vid_data, e.data);
      end
    end
    if (o_cpu_ack === 1'b1) begin
      if (cpu_q.size() == 0) begin
        check("cpu_ack_expected", cpu_q.size(), 1);
      end else begin
        e = cpu_q.pop_front();
        check_win("cpu_ack_cycle", cyc, e.lo, e.hi);
        if (e.chk_data) check("cpu_rdata", o_cpu_rdata, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Latencies are relative to the cycle the request is raised.
  task automatic cpu_op(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd, input int lo, input int hi);
    exp_t e;
    bit   got;
    i_cpu_req   = 1'b1;
    i_cpu_we    = we;
    i_cpu_addr  = addr;
    i_cpu_wdata = wd;
    e.lo = cyc + lo;
    e.hi = cyc + hi;
    e.data = rd;
    e.chk_data = !we;
    cpu_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge i_clk);
      got = o_cpu_ack;
    end
    check("cpu_ack_seen", 32'(got), 1);
    @(posedge i_clk);
    #1;
    i_cpu_req = 1'b0;
  endtask

  task automatic vid_strobe(input logic [12:0] addr, input logic [7:0] d,
                            input int lo, input int hi);
    exp_t e;
    i_vid_read = 1'b1;
    i_vid_addr = addr;
    e.lo = cyc + lo;
    e.hi = cyc + hi;
    e.data = d;
    e.chk_data = 1'b1;
    vid_q.push_back(e);
    tick(1);
    i_vid_read = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int en0;
    for (int i = 0; i < VRAM_BYTES; i++) ram[i] = pat(i);
    ram[13'h0123] = 8'hA5;
    i_rst = 1'b1;
    i_vid_read = 1'b0;
    i_vid_addr = '0;
    i_cpu_req = 1'b0;
    i_cpu_we = 1'b0;
    i_cpu_addr = '0;
    i_cpu_wdata = '0;
    tick(3);
    check("rst_vid_ready", o_vid_ready, 0);
    check("rst_cpu_ack", o_cpu_ack, 0);
    check("rst_mem_en", o_mem_en, 0);
    check("rst_mem_we", o_mem_we, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_vid_data", o_vid_data, 0);
    check("rst_cpu_rdata", o_cpu_rdata, 0);
`ifdef VRAM_ARB_STATS_EN
    check("rst_stall_cnt", o_stall_cnt, 0);
`endif
    i_rst = 1'b0;
    tick(2);

    // Idle video read: ready exactly three cycles after the strobe.
    vid_strobe(13'h0123, 8'hA5, 3, 3);
    tick(6);

    // CPU write then read back the last in-range byte.
    cpu_op(1'b1, 13'h1BFF, 8'h3C, 8'h00, 2, 2);
    cpu_op(1'b0, 13'h1BFF, 8'h00, 8'h3C, 3, 3);
    tick(4);

    // Same-cycle collision: video first, CPU ack three cycles later than usual.
    en0 = en_cnt;
    fork
      vid_strobe(13'h0040, pat(13'h0040), 3, 3);
      cpu_op(1'b0, 13'h0123, 8'h00, 8'hA5, 6, 6);
    join
    tick(3);
    check("collision_mem_en_pulses", en_cnt - en0, 2);
`ifdef VRAM_ARB_STATS_EN
    check("collision_stall_cnt", o_stall_cnt, 3);
`endif

    // Strobe lands in CRD: CPU unaffected, video ready five cycles after the CPU grant.
    fork
      cpu_op(1'b0, 13'h0200, 8'h00, pat(13'h0200), 3, 3);
      begin
        tick(1);
        vid_strobe(13'h0201, pat(13'h0201), 4, 4);
      end
    join
    tick(6);

    // Out-of-range read and write: no RAM access, read returns zero.
    en0 = en_cnt;
    cpu_op(1'b0, 13'h1C00, 8'h00, 8'h00, 2, 2);
    cpu_op(1'b1, 13'h1FFF, 8'hEE, 8'h00, 2, 2);
    tick(3);
    check("oob_mem_en_pulses", en_cnt - en0, 0);
    check("oob_ram_last_byte", ram[13'h1BFF], 8'h3C);

    // Video every 16 cycles against continuous CPU reads.
    vid_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          vid_strobe(13'(13'h0300 + k), pat(13'h0300 + k), 3, 5);
          tick(15);
        end
        vid_done = 1'b1;
      end
      begin
        for (int n = 0; n < 40 && !vid_done; n++)
          cpu_op(1'b0, 13'(13'h0400 + n), 8'h00, pat(13'h0400 + n), 3, 6);
      end
    join
    tick(8);
    check("stream_vid_q_drained", vid_q.size(), 0);

    // Reset during CDAT aborts the read without an ack.
    i_cpu_req  = 1'b1;
    i_cpu_we   = 1'b0;
    i_cpu_addr = 13'h0123;
    tick(2);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    i_cpu_req = 1'b0;
    @(negedge i_clk);
    check("abort_cpu_ack", o_cpu_ack, 0);
    check("abort_mem_en", o_mem_en, 0);
    check("abort_mem_addr", o_mem_addr, 0);
    check("abort_vid_data", o_vid_data, 0);
    check("abort_cpu_rdata", o_cpu_rdata, 0);
`ifdef VRAM_ARB_STATS_EN
    check("abort_stall_cnt", o_stall_cnt, 0);
`endif
    tick(6);

    check("final_vid_q_drained", vid_q.size(), 0);
    check("final_cpu_q_drained", cpu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
